mux_nx1_reg: RTL and testbench
==============================

MUX_NX1_REG -- requirements
Module: mux_nx1_reg

Interface
REQ-001 Parameter WIDTH, 8, bit width of each data channel; legal range 1..64.
REQ-002 Parameter N, 4, number of input channels; legal range 2..16, power of two not required.
REQ-003 Parameter SW, max(1,clog2(N)), width of sel and out_src; derived from N, not overridden.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports exactly as follows.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  N x WIDTH  per-channel data.
REQ-008 in_valid  input  N  per-channel data-valid.
REQ-009 in_ready  output  N  per-channel accept; combinational.
REQ-010 mode  input  1  0 = explicit select, 1 = round-robin.
REQ-011 sel  input  SW  channel index used in explicit mode; ignored in round-robin mode.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 out_src  output  SW  index of the channel that supplied out_data.

Function
REQ-016 load = !out_valid || out_ready; the output register SHALL accept a new word only when load is 1.
REQ-017 Explicit mode: in_ready[i] SHALL be load && (i == sel); a transfer SHALL occur when in_valid[sel] && in_ready[sel].
REQ-018 Explicit mode with sel >= N: all in_ready SHALL be 0 and no transfer SHALL occur.
REQ-019 Round-robin mode: grant SHALL be the first i with in_valid[i], searching ptr, ptr+1, ... modulo N; in_ready[grant] = load, all others 0.
REQ-020 Round-robin: on transfer, ptr SHALL become (grant+1) mod N, wrapping N-1 -> 0; with no transfer, ptr SHALL hold.
REQ-021 Explicit-mode transfers SHALL NOT modify ptr; mode is sampled every cycle, and ptr persists across mode changes.
REQ-022 On transfer, out_data, out_src and out_valid=1 SHALL update at the next edge; latency is exactly 1 cycle.
REQ-023 If load=1 and no transfer occurs, out_valid SHALL go to 0 at the next edge; out_data and out_src SHALL hold.
REQ-024 While out_valid && !out_ready, out_data and out_src SHALL be held stable and all in_ready SHALL be 0.
REQ-025 Simultaneous out_ready and transfer SHALL replace the output word with no bubble, sustaining 1 word/cycle.
REQ-026 in_ready SHALL NOT depend on in_valid of the same channel in explicit mode; no combinational path from out_ready to out_*.

Reset
REQ-027 While reset=1 at a clock edge: out_valid=0, out_data=0, out_src=0, ptr=0.
REQ-028 in_ready SHALL be all 0 while reset is asserted.
REQ-029 A word held in the output register when reset asserts SHALL be discarded and not presented after reset.

Structure
REQ-030 Package pepe_mux_pkg SHALL hold the mode enum (MUX_MODE_SEL=0, MUX_MODE_RR=1) and the SW derivation function.
REQ-031 The round-robin search SHALL be a sub-module rr_priority_pick (inputs: req[N], ptr; outputs: grant index, any).
REQ-032 Only the output register and ptr are state; there SHALL be no other storage.

Verification
REQ-033 N=4, WIDTH=8, explicit, sel=2, in_valid=0100, in_data[2]=0xA5, out_ready=1 -> in_ready=0100, next cycle out_data=0xA5, out_src=2, out_valid=1.
REQ-034 RR, all valid, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,3,0,1; ptr wraps 3->0.
REQ-035 RR, ptr=3, only in_valid[1]=1 -> grant 1, then ptr=2.
REQ-036 Output valid, out_ready=0 for 3 cycles with new inputs changing -> out_data and out_src stable, in_ready=0000; then out_ready=1 -> next word loads same edge.
REQ-037 N=3, explicit, sel=3 -> in_ready=000, out_valid falls to 0 after current word is taken.
REQ-038 Reset asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_data=0, out_src=0; first RR grant after reset is channel 0.

Source files
------------

// File: rtl/pepe_mux_pkg.sv
// Shared types and helpers for the registered N:1 multiplexer.
// Holds the mode encoding and the select-width derivation.
package pepe_mux_pkg;

    typedef enum logic {
        MUX_MODE_SEL = 1'b0,
        MUX_MODE_RR  = 1'b1
    } mux_mode_e;

    // A single channel index still needs one bit, so the width never drops below 1.
    function automatic int calc_sw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority search: returns the first requester at or after ptr,
// wrapping modulo N, plus a flag telling whether any request is present.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          any
);

    // Walking from the farthest offset back to ptr lets the closest requester win last.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N]) begin
                grant = SW'((int'(ptr) + off) % N);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_reg.sv
// Registered N:1 multiplexer with valid/ready handshakes, selectable between
// explicit channel select and round-robin arbitration.
module mux_nx1_reg
    import pepe_mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SW    = calc_sw(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0][WIDTH-1:0] in_data,
    input  logic [N-1:0]          in_valid,
    output logic [N-1:0]          in_ready,
    input  logic                  mode,
    input  logic [SW-1:0]         sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SW-1:0]         out_src
);

    logic             mode_rr;
    logic             load;
    logic             sel_valid;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    rr_grant;
    logic             rr_any;
    logic [SW-1:0]    grant;
    logic             any_req;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    assign mode_rr = (mux_mode_e'(mode) == MUX_MODE_RR);
    assign load    = !out_valid || out_ready;

    rr_priority_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (rr_grant),
        .any   (rr_any)
    );

    // Loop-based lookups keep an out-of-range sel from indexing past the channel array.
    always_comb begin
        sel_valid  = 1'b0;
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                sel_valid = in_valid[i];
            end
        end
        grant   = mode_rr ? rr_grant : sel;
        any_req = mode_rr ? rr_any : sel_valid;
        for (int i = 0; i < N; i++) begin
            if (grant == SW'(i)) begin
                grant_data = in_data[i];
            end
            if (!reset && load) begin
                in_ready[i] = mode_rr ? (rr_any && (rr_grant == SW'(i))) : (sel == SW'(i));
            end
        end
        xfer = load && any_req && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (xfer && mode_rr) begin
            ptr <= (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
        end
    end

    // Output register: refills only when empty or drained downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= grant_data;
                out_src  <= grant;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg: a behavioural model feeds a scoreboard
// queue on each accepted word, compared against the registered output.
module tb_mux_nx1_reg;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0][7:0] in_data;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic            mode;
    logic [1:0]      sel;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_src;

    logic [2:0][7:0] d3;
    logic [2:0]      v3;
    logic [2:0]      r3;
    logic            mode3;
    logic [1:0]      sel3;
    logic [7:0]      od3;
    logic            ov3;
    logic            ordy3;
    logic [1:0]      os3;

    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
    } word_t;

    word_t sb[$];
    int    m_ptr;
    bit    m_valid;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mux_nx1_reg #(.WIDTH(8), .N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    mux_nx1_reg #(.WIDTH(8), .N(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (d3),
        .in_valid  (v3),
        .in_ready  (r3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (od3),
        .out_valid (ov3),
        .out_ready (ordy3),
        .out_src   (os3)
    );

    function automatic void model_pick(output logic [1:0] g, output bit any);
        g   = 2'd0;
        any = 1'b0;
        if (!mode) begin
            g   = sel;
            any = in_valid[sel];
        end else begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (in_valid[idx]) begin
                    g   = 2'(idx);
                    any = 1'b1;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [1:0] g;
        bit         any;
        bit         ld;
        ld = !m_valid || out_ready;
        model_pick(g, any);
        if (reset || !ld) return 4'b0000;
        if (!mode) return 4'b0001 << sel;
        return any ? (4'b0001 << g) : 4'b0000;
    endfunction

    task automatic tick();
        logic [1:0] g;
        bit         any;
        bit         ld;
        @(posedge clk);
        ld = !m_valid || out_ready;
        if (reset) begin
            sb.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
        end else begin
            model_pick(g, any);
            if (ld && m_valid && sb.size() > 0) void'(sb.pop_front());
            if (ld && any) begin
                sb.push_back('{d: in_data[g], s: g});
                if (mode) m_ptr = (int'(g) + 1) % 4;
            end
            if (ld) m_valid = any;
        end
        #1;
    endtask

    task automatic randomize_inputs(input bit allow_rr);
        mode      = allow_rr ? 1'($urandom_range(0, 1)) : 1'b0;
        sel       = 2'($urandom_range(0, 3));
        in_valid  = 4'($urandom_range(0, 15));
        out_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        tick();
        tick();
        checks++;
        if ({out_valid, out_data, out_src} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h src=%0d want 0/00/0",
                     out_valid, out_data, out_src);
        end
        reset = 1'b0;
    endtask

    task automatic test_explicit();
        mode        = 1'b0;
        sel         = 2'd2;
        in_valid    = 4'b0100;
        in_data     = '0;
        in_data[2]  = 8'hA5;
        out_ready   = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL explicit_in_ready: got %b want 0100", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin
            errors++;
            $display("[TB] FAIL explicit_word: got valid=%b data=%h src=%0d want 1/a5/2",
                     out_valid, out_data, out_src);
        end
        for (int c = 0; c < 20; c++) begin
            randomize_inputs(1'b0);
            #1;
            checks++;
            if (in_ready !== exp_ready()) begin
                errors++;
                $display("[TB] FAIL explicit_rand_ready: got %b want %b", in_ready, exp_ready());
            end
            tick();
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("[TB] FAIL explicit_rand_valid: got %b want %b", out_valid, m_valid);
            end
            if (m_valid && sb.size() > 0) begin
                checks++;
                if (out_data !== sb[0].d || out_src !== sb[0].s) begin
                    errors++;
                    $display("[TB] FAIL explicit_rand_word: got %h/%0d want %h/%0d",
                             out_data, out_src, sb[0].d, sb[0].s);
                end
            end
        end
    endtask

    task automatic test_rr_sequence();
        logic [1:0] seq [6];
        seq       = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (in_ready !== (4'b0001 << seq[c])) begin
                errors++;
                $display("[TB] FAIL rr_seq_ready[%0d]: got %b want %b", c, in_ready, 4'b0001 << seq[c]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== seq[c] || out_data !== in_data[seq[c]]) begin
                errors++;
                $display("[TB] FAIL rr_seq_word[%0d]: got valid=%b src=%0d data=%h want 1/%0d/%h",
                         c, out_valid, out_src, out_data, seq[c], in_data[seq[c]]);
            end
        end
    endtask

    task automatic test_rr_ptr_skip();
        in_valid = 4'b0100;
        tick();
        in_valid = 4'b0010;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL rr_skip_ready: got %b want 0010", in_ready);
        end
        tick();
        checks++;
        if (out_src !== 2'd1 || out_data !== 8'h22) begin
            errors++;
            $display("[TB] FAIL rr_skip_word: got src=%0d data=%h want 1/22", out_src, out_data);
        end
        in_valid = 4'b1111;
        tick();
        checks++;
        if (out_src !== 2'd2) begin
            errors++;
            $display("[TB] FAIL rr_skip_ptr: got src=%0d want 2", out_src);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held_d;
        logic [1:0] held_s;
        held_d    = out_data;
        held_s    = out_src;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mode     = 1'(c % 2);
            sel      = 2'(c);
            in_valid = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL stall_ready[%0d]: got %b want 0000", c, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_src !== held_s) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got %b/%h/%0d want 1/%h/%0d",
                         c, out_valid, out_data, out_src, held_d, held_s);
            end
        end
        mode      = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL release_ready: got %b want 1000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 8'hD4) begin
            errors++;
            $display("[TB] FAIL release_word: got %b/%0d/%h want 1/3/d4", out_valid, out_src, out_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 40; c++) begin
            randomize_inputs(1'b1);
            #1;
            checks++;
            if (in_ready !== exp_ready()) begin
                errors++;
                $display("[TB] FAIL b2b_ready[%0d]: got %b want %b", c, in_ready, exp_ready());
            end
            tick();
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("[TB] FAIL b2b_valid[%0d]: got %b want %b", c, out_valid, m_valid);
            end
            if (m_valid && sb.size() > 0) begin
                checks++;
                if (out_data !== sb[0].d || out_src !== sb[0].s) begin
                    errors++;
                    $display("[TB] FAIL b2b_word[%0d]: got %h/%0d want %h/%0d",
                             c, out_data, out_src, sb[0].d, sb[0].s);
                end
            end
        end
    endtask

    task automatic test_reset_midword();
        mode      = 1'b0;
        sel       = 2'd3;
        in_valid  = 4'b1000;
        in_data   = {8'h77, 8'h66, 8'h55, 8'h44};
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            errors++;
            $display("[TB] FAIL midword_setup: got %b/%h want 1/77", out_valid, out_data);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
            errors++;
            $display("[TB] FAIL midword_reset: got %b/%h/%0d want 0/00/0", out_valid, out_data, out_src);
        end
        reset     = 1'b0;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'h44) begin
            errors++;
            $display("[TB] FAIL midword_first_grant: got %b/%0d/%h want 1/0/44", out_valid, out_src, out_data);
        end
    endtask

    task automatic test_n3_sel_oob();
        sel3  = 2'd0;
        v3    = 3'b001;
        d3    = {8'h0C, 8'h0B, 8'h5A};
        ordy3 = 1'b1;
        @(posedge clk);
        #1;
        sel3  = 2'd3;
        v3    = 3'b111;
        ordy3 = 1'b0;
        #1;
        checks++;
        if (ov3 !== 1'b1 || od3 !== 8'h5A || os3 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL n3_word: got %b/%h/%0d want 1/5a/0", ov3, od3, os3);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ov3 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL n3_hold: got valid=%b want 1", ov3);
        end
        ordy3 = 1'b1;
        #1;
        checks++;
        if (r3 !== 3'b000) begin
            errors++;
            $display("[TB] FAIL n3_oob_ready: got %b want 000", r3);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ov3 !== 1'b0 || od3 !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL n3_oob_drain: got %b/%h want 0/5a", ov3, od3);
        end
    endtask

    initial begin
        m_ptr   = 0;
        m_valid = 1'b0;
        reset   = 1'b1;
        mode    = 1'b0;
        sel     = 2'd0;
        in_valid = '0;
        in_data  = '0;
        out_ready = 1'b0;
        mode3 = 1'b0;
        sel3  = 2'd0;
        v3    = '0;
        d3    = '0;
        ordy3 = 1'b0;
        test_reset();
        test_explicit();
        test_rr_sequence();
        test_rr_ptr_skip();
        test_backpressure();
        test_back_to_back();
        test_reset_midword();
        test_n3_sel_oob();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
